sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Sits directly downstream of the CPU core's instruction and data memory ports.
- Merges the two sram-like masters (inst, data) onto one sram-like slave port toward the memory/AXI bridge.
- Uses fixed data-over-inst priority, a request lock, and an in-order tag FIFO that routes each returned response to the master that issued it.
- Several transactions may be outstanding at once.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 4, max in-flight transactions; power of 2, >=2

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  inst master request valid
inst_wr  in  1  inst write (1) / read (0)
inst_size  in  2  0=byte 1=half 2=word
inst_addr  in  ADDR_W  inst address
inst_wdata  in  DATA_W  inst write data
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst response returned this cycle
inst_rdata  out  DATA_W  inst read data
data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/ADDR_W/DATA_W  data master request, same meaning as inst_*
data_addr_ok / data_data_ok  out  1/1  data master accept / response
data_rdata  out  DATA_W  data read data
mem_req  out  1  slave request valid
mem_wr / mem_size / mem_addr / mem_wdata  out  1/2/ADDR_W/DATA_W  fields muxed from the granted master
mem_addr_ok  in  1  slave accepts request
mem_data_ok  in  1  slave response valid (in order)
mem_rdata  in  DATA_W  slave read data
err_unexp_rsp  out  1  sticky: mem_data_ok seen with FIFO empty

Behaviour:
- Reset: on resetn low, immediately clear FIFO, count, lock and err_unexp_rsp.
  - All outputs are 0 while held in reset: mem_req, all addr_ok/data_ok, err_unexp_rsp; muxed fields and rdata are 0 or don't-care.
  - Reset mid-transaction drops all tags; later stray mem_data_ok sets err_unexp_rsp.
- Grant (combinational): full = (count==MAX_OUTST).
  - If lock_valid: grant = lock_id.
  - Else if data_req: grant = DATA.
  - Else if inst_req: grant = INST.
- mem_req = ~full & (granted master's req); mem_wr/size/addr/wdata come from the granted master.
- Lock: set lock_valid and lock_id = grant when mem_req & ~mem_addr_ok. This keeps the presented request stable until accepted, even if a higher-priority req arrives.
  - Clear the lock on mem_req & mem_addr_ok.
  - If the locked master drops req (protocol violation), mem_req drops and the lock clears the next cycle.
- Accept: {inst,data}_addr_ok = mem_addr_ok & mem_req & (grant==that master), combinational with zero added latency. The non-granted master sees addr_ok=0.
- Tag FIFO: depth MAX_OUTST, 1-bit master id, pointers wrap modulo MAX_OUTST, count width clog2(MAX_OUTST)+1.
  - push = mem_req & mem_addr_ok, writes grant.
  - pop = mem_data_ok & (count!=0).
  - Simultaneous push and pop: count unchanged, both pointers advance. Push into a full FIFO is impossible (mem_req is gated).
- Response routing (combinational): head = FIFO[rd_ptr]. inst_data_ok = pop & head==INST; data_data_ok = pop & head==DATA. Both rdata outputs = mem_rdata.
- mem_data_ok with count==0: no data_ok is asserted and err_unexp_rsp is set (sticky until reset).
- Full: mem_req=0 and both addr_ok=0 until a pop. A pop and a new request in the same cycle is allowed: full is evaluated on the registered count, so the request waits one cycle.
- Ordering: responses return in the issue order of mem accepts. Same-cycle accept + response is legal (response belongs to the older head).

Decomposition:
- Shared package/header: MST_INST=1'b0 and MST_DATA=1'b1 ids; size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module: tag_fifo (parameterised depth/width sync FIFO with count, full, empty, async active-low reset), reusable by the later AXI bridge.

Test Plan:
- Both req=1 same cycle, mem_addr_ok=1: data_addr_ok=1, inst_addr_ok=0; inst accepted next cycle; mem_data_ok twice -> data_data_ok then inst_data_ok, rdata 0x11111111/0x22222222 routed accordingly.
- Lock: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays inst_addr 0xBFC00000 until accept; data granted afterwards.
- Full: MAX_OUTST=4, 4 accepts with no responses -> mem_req=0, both addr_ok=0; one mem_data_ok -> next cycle mem_req=1 again, count returns to 4 after accept.
- Simultaneous push/pop at count=2 -> count stays 2, head id correct, pointer wrap exercised over 10 transactions.
- mem_data_ok with FIFO empty -> no data_ok, err_unexp_rsp=1 and stays 1.
- Assert resetn=0 with 3 outstanding -> all outputs 0 immediately; after release count=0, first new request accepted normally.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter and its tag FIFO.
// Master ids are stored in the tag FIFO, and access sizes are passed through unchanged.
package sram_like_arbiter_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/sram_like_arbiter_tag_fifo.sv
// Synchronous FIFO with an occupancy count and an asynchronous active-low reset.
// DEPTH must be a power of two. Push when full and pop when empty are ignored.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data sram-like masters onto a single slave port. Data has priority
// over inst, and a presented request is locked until it is accepted. Responses are routed in order via a tag FIFO.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_unexp_rsp
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic             grant_s, granted_req_s, full_s, empty_s, push_s, pop_s, head_s;
  logic [CNT_W-1:0] count_s;
  logic             lock_valid_q, lock_valid_d, lock_id_q, lock_id_d, err_q, err_d;

  always_comb begin
    grant_s = MST_INST;
    if (lock_valid_q) begin
      grant_s = lock_id_q;
    end else if (data_req) begin
      grant_s = MST_DATA;
    end else begin
      grant_s = MST_INST;
    end
  end

  assign granted_req_s = (grant_s == MST_DATA) ? data_req : inst_req;
  // Gating with resetn keeps the combinational request low while reset is held.
  assign mem_req   = resetn & ~full_s & granted_req_s;
  assign mem_wr    = (grant_s == MST_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant_s == MST_DATA) ? data_size  : inst_size;
  assign mem_addr  = (grant_s == MST_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant_s == MST_DATA) ? data_wdata : inst_wdata;

  assign push_s       = mem_req & mem_addr_ok;
  assign pop_s        = mem_data_ok & (count_s != {CNT_W{1'b0}});
  assign inst_addr_ok = push_s & (grant_s == MST_INST);
  assign data_addr_ok = push_s & (grant_s == MST_DATA);
  assign inst_data_ok = pop_s & (head_s == MST_INST);
  assign data_data_ok = pop_s & (head_s == MST_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_unexp_rsp = err_q;

  always_comb begin
    lock_valid_d = 1'b0;
    lock_id_d    = lock_id_q;
    if (mem_req & ~mem_addr_ok) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant_s;
    end else begin
      lock_valid_d = 1'b0;
    end
    err_d = err_q | (mem_data_ok & empty_s);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= MST_INST;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      err_q        <= err_d;
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push_s),
    .wdata_i (grant_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and random bench for sram_like_arbiter. The reference model is a queue of
// issuing master ids plus a "presented request is held" flag.
module tb_sram_like_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_wdata, inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_unexp_rsp;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit held_v   = 1'b0;
  int held_id  = 0;
  bit err_m    = 1'b0;
  bit acc_inst = 1'b0;
  bit acc_data = 1'b0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .err_unexp_rsp(err_unexp_rsp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_inst();
    inst_wr    = ($urandom_range(0, 1) != 0);
    inst_size  = 2'($urandom_range(0, 2));
    inst_addr  = $urandom;
    inst_wdata = $urandom;
  endtask

  task automatic new_data();
    data_wr    = ($urandom_range(0, 1) != 0);
    data_size  = 2'($urandom_range(0, 2));
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  // One clock cycle: inputs are already driven, outputs are checked at the falling edge, and then the model advances.
  task automatic cycle();
    int pres;
    bit pres_req, mreq, pop, was_empty;
    int head;
    @(negedge clk);
    if (!resetn) begin
      exp_q.delete();
      held_v = 1'b0;
      err_m  = 1'b0;
    end
    pres = -1;
    if (held_v) pres = held_id;
    else if (data_req) pres = 1;
    else if (inst_req) pres = 0;
    pres_req  = (pres == 1) ? data_req : ((pres == 0) ? inst_req : 1'b0);
    mreq      = resetn && pres_req && (exp_q.size() < MO);
    was_empty = (exp_q.size() == 0);
    pop       = resetn && mem_data_ok && !was_empty;
    head      = pop ? exp_q[0] : -1;
    chk("mem_req", 128'(mem_req), 128'(mreq));
    if (mreq) begin
      chk("mem_fields", 128'({mem_wr, mem_size, mem_addr, mem_wdata}),
          (pres == 1) ? 128'({data_wr, data_size, data_addr, data_wdata})
                      : 128'({inst_wr, inst_size, inst_addr, inst_wdata}));
    end
    acc_inst = mreq && mem_addr_ok && (pres == 0);
    acc_data = mreq && mem_addr_ok && (pres == 1);
    chk("inst_addr_ok", 128'(inst_addr_ok), 128'(acc_inst));
    chk("data_addr_ok", 128'(data_addr_ok), 128'(acc_data));
    chk("inst_data_ok", 128'(inst_data_ok), 128'(pop && head == 0));
    chk("data_data_ok", 128'(data_data_ok), 128'(pop && head == 1));
    if (pop) begin
      chk("rdata", 128'((head == 1) ? data_rdata : inst_rdata), 128'(mem_rdata));
    end
    chk("err_unexp_rsp", 128'(err_unexp_rsp), 128'(err_m));
    if (resetn) begin
      if (pop) void'(exp_q.pop_front());
      if (mreq && mem_addr_ok) exp_q.push_back(pres);
      if (mem_data_ok && was_empty) err_m = 1'b1;
      held_v  = mreq && !mem_addr_ok;
      held_id = pres;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    while (exp_q.size() > 0) begin
      mem_rdata = $urandom;
      cycle();
    end
    mem_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    new_inst(); new_data();
    @(posedge clk); #1;

    // Reset state: all outputs stay low while reset is held, even with every input high.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    cycle(); cycle();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    resetn = 1'b1;
    cycle();

    // When both masters request in the same cycle, data wins; responses then return in issue order.
    new_inst(); new_data();
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    cycle();
    data_req = 1'b0;
    cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h11111111;
    cycle();
    mem_rdata = 32'h22222222;
    cycle();
    mem_data_ok = 1'b0;

    // Lock: the inst request stays presented while data_req rises during the stall.
    new_inst(); inst_addr = 32'hBFC00000; inst_req = 1'b1; mem_addr_ok = 1'b0;
    cycle();
    new_data(); data_req = 1'b1;
    cycle(); cycle();
    mem_addr_ok = 1'b1;
    cycle();
    inst_req = 1'b0;
    cycle();
    drain();

    // Full: four accepts, then the port stalls until a response drains a slot.
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      new_inst(); new_data();
      data_req = ((i % 2) == 1);
      inst_req = ((i % 2) == 0);
      cycle();
    end
    new_inst(); new_data();
    inst_req = 1'b1; data_req = 1'b1;
    cycle(); cycle();
    mem_data_ok = 1'b1; mem_rdata = $urandom;
    cycle();
    mem_data_ok = 1'b0;
    cycle(); cycle();
    drain();

    // Simultaneous push and pop at count 2, enough transactions to wrap the pointers.
    mem_addr_ok = 1'b1; data_req = 1'b1;
    new_data(); cycle();
    new_data(); cycle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      new_inst(); new_data();
      data_req = ($urandom_range(0, 1) != 0);
      inst_req = !data_req;
      mem_rdata = $urandom;
      cycle();
    end
    drain();

    // Random traffic: each master holds its request until it is accepted.
    for (int i = 0; i < 3000; i++) begin
      if (acc_inst || !inst_req) begin
        inst_req = ($urandom_range(0, 2) != 0);
        new_inst();
      end
      if (acc_data || !data_req) begin
        data_req = ($urandom_range(0, 2) != 0);
        new_data();
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata   = $urandom;
      cycle();
    end
    drain();

    // A stray response with the FIFO empty raises the sticky error.
    mem_data_ok = 1'b1; mem_rdata = $urandom;
    cycle();
    mem_data_ok = 1'b0;
    cycle(); cycle();

    // Reset with three transactions outstanding; a later stray response raises the error again.
    mem_addr_ok = 1'b1; inst_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_inst();
      cycle();
    end
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    cycle();
    resetn = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    cycle();
    resetn = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    cycle();
    mem_data_ok = 1'b0;
    cycle();
    new_inst(); inst_req = 1'b1; mem_addr_ok = 1'b1;
    cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = $urandom;
    cycle();
    mem_data_ok = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
